// File: rtl/usb2_ulpi_regarb.sv
// usb2_ulpi_regarb
// Round-robin arbiter and sequencer for ULPI PHY register reads/writes issued
// by two requesters (link-control FSM on port 0, debug/config on port 1).
// The block drives the ULPI link-side pins only while a register transaction
// is in flight (bus_own=1); the packet path muxes phy_d_out/phy_stp in on it.
//
// Ports:
//   phy_clk, reset               60 MHz ULPI clock, async active-high reset
//   reqN_valid/write/addr/wdata  request N (held until reqN_ack or reqN_err)
//   reqN_ack / reqN_err          one-cycle completion / failure pulses
//   rdata                        read result, valid with the ack of a read
//   bus_busy                     packet layer owns the bus, no new grant
//   bus_own                      this block drives phy_d_out / phy_stp
//   phy_dir, phy_nxt, phy_d_in   ULPI inputs from the PHY
//   phy_d_out, phy_stp           ULPI outputs to the PHY
module usb2_ulpi_regarb #(
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic       phy_clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req0_write,
  input  logic [5:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic       req0_ack,
  output logic       req0_err,
  input  logic       req1_valid,
  input  logic       req1_write,
  input  logic [5:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       req1_ack,
  output logic       req1_err,
  output logic [7:0] rdata,
  input  logic       bus_busy,
  output logic       bus_own,
  input  logic       phy_dir,
  input  logic       phy_nxt,
  input  logic [7:0] phy_d_in,
  output logic [7:0] phy_d_out,
  output logic       phy_stp
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CMD       = 3'd1,
    S_WDATA     = 3'd2,
    S_STP       = 3'd3,
    S_RD_TURN   = 3'd4,
    S_RD_DATA   = 3'd5,
    S_WAIT_IDLE = 3'd6,
    S_ABORT     = 3'd7
  } state_t;

  // The last wait cycle that may still see progress; reaching it again fails.
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

  // ULPI command byte: 2'b10 = RegWrite, 2'b11 = RegRead, immediate address.
  function automatic logic [7:0] cmd_byte(input logic wr, input logic [5:0] addr);
    return {(wr ? 2'b10 : 2'b11), addr};
  endfunction

  state_t      state_r, state_s;
  logic        dir_1_r;
  logic        rr_r, rr_s;
  logic        gnt_r, gnt_s;
  logic        wr_r, wr_s;
  logic [5:0]  addr_r, addr_s;
  logic [7:0]  wdata_r, wdata_s;
  logic [1:0]  retry_r, retry_s;
  logic [7:0]  timer_r, timer_s;
  logic [7:0]  d_out_r, d_out_s;
  logic        stp_r, stp_s;
  logic        own_r, own_s;
  logic [7:0]  rdata_r, rdata_s;
  logic        ack0_r, ack0_s, ack1_r, ack1_s;
  logic        err0_r, err0_s, err1_r, err1_s;
  logic        done_s, fail_s;

  logic        bus_free_s;
  logic        pulse_s;
  logic        pick_s;
  logic        pick_wr_s;
  logic [5:0]  pick_addr_s;
  logic [7:0]  pick_wdata_s;

  // Bus is free only when DIR has been low for two samples and the packet
  // layer is idle, so a turnaround cycle is never overlapped.
  assign bus_free_s = ~phy_dir & ~dir_1_r & ~bus_busy;
  // While a completion pulse is out, the requester has not yet dropped or
  // replaced its request; granting now would repeat the finished access.
  assign pulse_s    = ack0_r | ack1_r | err0_r | err1_r;
  // Both pending: honour the round-robin pointer; otherwise the lone one.
  assign pick_s       = (req0_valid && req1_valid) ? rr_r : req1_valid;
  assign pick_wr_s    = pick_s ? req1_write : req0_write;
  assign pick_addr_s  = pick_s ? req1_addr  : req0_addr;
  assign pick_wdata_s = pick_s ? req1_wdata : req0_wdata;

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    state_s = state_r;
    d_out_s = 8'h00;
    stp_s   = 1'b0;
    own_s   = 1'b0;
    rdata_s = rdata_r;
    gnt_s   = gnt_r;
    wr_s    = wr_r;
    addr_s  = addr_r;
    wdata_s = wdata_r;
    retry_s = retry_r;
    timer_s = timer_r;
    done_s  = 1'b0;
    fail_s  = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (bus_free_s && !pulse_s && (req0_valid || req1_valid)) begin
          gnt_s   = pick_s;
          wr_s    = pick_wr_s;
          addr_s  = pick_addr_s;
          wdata_s = pick_wdata_s;
          retry_s = 2'd0;
          timer_s = 8'd0;
          own_s   = 1'b1;
          d_out_s = cmd_byte(pick_wr_s, pick_addr_s);
          state_s = S_CMD;
        end else begin
          state_s = S_IDLE;
        end
      end

      S_CMD: begin
        if (phy_dir) begin
          // PHY took the bus mid-command: release without STP.
          state_s = S_ABORT;
        end else if (phy_nxt) begin
          timer_s = 8'd0;
          own_s   = 1'b1;
          if (wr_r) begin
            d_out_s = wdata_r;
            state_s = S_WDATA;
          end else begin
            d_out_s = 8'h00;
            state_s = S_RD_TURN;
          end
        end else if (timer_r == TMO_LAST) begin
          fail_s  = 1'b1;
          state_s = S_IDLE;
        end else begin
          timer_s = timer_r + 8'd1;
          own_s   = 1'b1;
          d_out_s = cmd_byte(wr_r, addr_r);
        end
      end

      S_WDATA: begin
        if (phy_dir) begin
          state_s = S_ABORT;
        end else if (phy_nxt) begin
          timer_s = 8'd0;
          own_s   = 1'b1;
          stp_s   = 1'b1;
          d_out_s = 8'h00;
          state_s = S_STP;
        end else if (timer_r == TMO_LAST) begin
          fail_s  = 1'b1;
          state_s = S_IDLE;
        end else begin
          timer_s = timer_r + 8'd1;
          own_s   = 1'b1;
          d_out_s = wdata_r;
        end
      end

      S_STP: begin
        if (phy_dir) begin
          // DIR rising while STP is out: the write did not land, retry it.
          state_s = S_ABORT;
        end else begin
          done_s  = 1'b1;
          state_s = S_IDLE;
        end
      end

      S_RD_TURN: begin
        if (phy_dir) begin
          if (phy_nxt) begin
            // NXT with DIR rising means a receive packet pre-empted the read.
            state_s = S_ABORT;
          end else begin
            timer_s = 8'd0;
            state_s = S_RD_DATA;
          end
        end else if (timer_r == TMO_LAST) begin
          fail_s  = 1'b1;
          state_s = S_IDLE;
        end else begin
          timer_s = timer_r + 8'd1;
          own_s   = 1'b1;
          d_out_s = 8'h00;
        end
      end

      S_RD_DATA: begin
        rdata_s = phy_d_in;
        done_s  = 1'b1;
        state_s = S_WAIT_IDLE;
      end

      S_WAIT_IDLE: begin
        if (!phy_dir) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_WAIT_IDLE;
        end
      end

      S_ABORT: begin
        if (!phy_dir && !dir_1_r) begin
          if (retry_r < RETRY_MAX) begin
            // Reissue the latched request without re-arbitrating.
            retry_s = retry_r + 2'd1;
            timer_s = 8'd0;
            own_s   = 1'b1;
            d_out_s = cmd_byte(wr_r, addr_r);
            state_s = S_CMD;
          end else begin
            fail_s  = 1'b1;
            state_s = S_IDLE;
          end
        end else begin
          state_s = S_ABORT;
        end
      end

      default: begin
        state_s = S_IDLE;
      end
    endcase

    ack0_s = done_s & ~gnt_r;
    ack1_s = done_s &  gnt_r;
    err0_s = fail_s & ~gnt_r;
    err1_s = fail_s &  gnt_r;
    // The pointer only passes on once the granted requester is finished.
    rr_s   = (done_s | fail_s) ? ~gnt_r : rr_r;
  end

  // State, latched request and registered outputs.
  always_ff @(posedge phy_clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      dir_1_r <= 1'b0;
      rr_r    <= 1'b0;
      gnt_r   <= 1'b0;
      wr_r    <= 1'b0;
      addr_r  <= 6'h00;
      wdata_r <= 8'h00;
      retry_r <= 2'd0;
      timer_r <= 8'd0;
      d_out_r <= 8'h00;
      stp_r   <= 1'b0;
      own_r   <= 1'b0;
      rdata_r <= 8'h00;
      ack0_r  <= 1'b0;
      ack1_r  <= 1'b0;
      err0_r  <= 1'b0;
      err1_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      dir_1_r <= phy_dir;
      rr_r    <= rr_s;
      gnt_r   <= gnt_s;
      wr_r    <= wr_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      retry_r <= retry_s;
      timer_r <= timer_s;
      d_out_r <= d_out_s;
      stp_r   <= stp_s;
      own_r   <= own_s;
      rdata_r <= rdata_s;
      ack0_r  <= ack0_s;
      ack1_r  <= ack1_s;
      err0_r  <= err0_s;
      err1_r  <= err1_s;
    end
  end

  assign phy_d_out = d_out_r;
  assign phy_stp   = stp_r;
  assign bus_own   = own_r;
  assign rdata     = rdata_r;
  assign req0_ack  = ack0_r;
  assign req1_ack  = ack1_r;
  assign req0_err  = err0_r;
  assign req1_err  = err1_r;

endmodule

// File: tb/tb_usb2_ulpi_regarb.sv
// Directed testbench for usb2_ulpi_regarb: writes, reads, round-robin
// alternation, abort/retry, timeout, bus_busy blocking and async reset.
module tb_usb2_ulpi_regarb;

  logic       phy_clk;
  logic       reset;
  logic       req0_valid, req0_write, req0_ack, req0_err;
  logic [5:0] req0_addr;
  logic [7:0] req0_wdata;
  logic       req1_valid, req1_write, req1_ack, req1_err;
  logic [5:0] req1_addr;
  logic [7:0] req1_wdata;
  logic [7:0] rdata;
  logic       bus_busy, bus_own;
  logic       phy_dir, phy_nxt, phy_stp;
  logic [7:0] phy_d_in, phy_d_out;

  int         tests_run = 0;
  int         tests_failed = 0;
  int         stp_seen;
  logic [5:0] exp_addr;
  logic [7:0] exp_data;
  logic [1:0] exp_ack;

  usb2_ulpi_regarb dut (
    .phy_clk    (phy_clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_write (req0_write),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ack   (req0_ack),
    .req0_err   (req0_err),
    .req1_valid (req1_valid),
    .req1_write (req1_write),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ack   (req1_ack),
    .req1_err   (req1_err),
    .rdata      (rdata),
    .bus_busy   (bus_busy),
    .bus_own    (bus_own),
    .phy_dir    (phy_dir),
    .phy_nxt    (phy_nxt),
    .phy_d_in   (phy_d_in),
    .phy_d_out  (phy_d_out),
    .phy_stp    (phy_stp)
  );

  initial phy_clk = 1'b0;
  always #5 phy_clk = ~phy_clk;

  task automatic tick();
    @(posedge phy_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_own(input string tag);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_own) break;
    end
    chk(tag, {31'd0, bus_own}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 6'h00; req0_wdata = 8'h00;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 6'h00; req1_wdata = 8'h00;
    bus_busy = 1'b0; phy_dir = 1'b0; phy_nxt = 1'b0; phy_d_in = 8'h00;
    repeat (3) tick();
    chk("rst_dout", {24'd0, phy_d_out}, 32'd0);
    chk("rst_stp_own", {30'd0, phy_stp, bus_own}, 32'd0);
    chk("rst_ackerr", {28'd0, req0_ack, req1_ack, req0_err, req1_err}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    tick();

    // Write 0x45 to 0x04 via req0; NXT delayed by one extra CMD cycle.
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 6'h04; req0_wdata = 8'h45;
    tick();
    chk("wr_cmd", {24'd0, phy_d_out}, 32'h84);
    chk("wr_own", {31'd0, bus_own}, 32'd1);
    tick();
    chk("wr_cmd_hold", {24'd0, phy_d_out}, 32'h84);
    phy_nxt = 1'b1;
    tick();
    chk("wr_data", {24'd0, phy_d_out}, 32'h45);
    tick();
    chk("wr_stp", {23'd0, phy_stp, phy_d_out}, 32'h100);
    chk("wr_no_early_ack", {31'd0, req0_ack}, 32'd0);
    phy_nxt = 1'b0;
    tick();
    chk("wr_ack", {29'd0, req0_ack, req1_ack, phy_stp}, 32'b100);
    chk("wr_own_fall", {31'd0, bus_own}, 32'd0);
    req0_valid = 1'b0;
    tick();
    chk("wr_ack_once", {31'd0, req0_ack}, 32'd0);

    // Read 0x0A via req0; PHY returns 0x5A after turnaround.
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 6'h0A;
    tick();
    chk("rd_cmd", {24'd0, phy_d_out}, 32'hCA);
    phy_nxt = 1'b1;
    tick();
    chk("rd_turn", {23'd0, bus_own, phy_d_out}, 32'h100);
    phy_nxt = 1'b0; phy_dir = 1'b1;
    tick();
    chk("rd_own_dir", {30'd0, bus_own, phy_stp}, 32'd0);
    phy_d_in = 8'h5A;
    tick();
    chk("rd_data_ack", {23'd0, req0_ack, rdata}, 32'h15A);
    chk("rd_own", {31'd0, bus_own}, 32'd0);
    req0_valid = 1'b0; phy_dir = 1'b0; phy_d_in = 8'h00;
    tick();
    chk("rd_hold", {23'd0, req0_ack, rdata}, 32'h05A);
    tick();

    // Round robin: both valid, four writes each, must alternate 0,1,0,1...
    do_reset();
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 6'h10; req0_wdata = 8'hA0;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 6'h20; req1_wdata = 8'hB0;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        exp_addr = 6'h10 + 6'(k / 2); exp_data = 8'hA0 + 8'(k / 2); exp_ack = 2'b01;
      end else begin
        exp_addr = 6'h20 + 6'(k / 2); exp_data = 8'hB0 + 8'(k / 2); exp_ack = 2'b10;
      end
      wait_own("rr_own");
      chk("rr_cmd", {24'd0, phy_d_out}, {24'd0, 2'b10, exp_addr});
      phy_nxt = 1'b1;
      tick();
      chk("rr_data", {24'd0, phy_d_out}, {24'd0, exp_data});
      tick();
      chk("rr_stp", {31'd0, phy_stp}, 32'd1);
      phy_nxt = 1'b0;
      tick();
      chk("rr_ack", {30'd0, req1_ack, req0_ack}, {30'd0, exp_ack});
      if (k % 2 == 0) begin
        req0_addr = req0_addr + 6'd1; req0_wdata = req0_wdata + 8'd1;
        if (k == 6) req0_valid = 1'b0;
      end else begin
        req1_addr = req1_addr + 6'd1; req1_wdata = req1_wdata + 8'd1;
        if (k == 7) req1_valid = 1'b0;
      end
    end

    // Two aborts during CMD, then completion with the same request.
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 6'h15; req0_wdata = 8'h3C;
    wait_own("ab_own");
    chk("ab_cmd", {24'd0, phy_d_out}, 32'h95);
    for (int a = 0; a < 2; a++) begin
      phy_dir = 1'b1;
      tick();
      chk("ab_release", {22'd0, bus_own, phy_stp, phy_d_out}, 32'd0);
      chk("ab_no_ack", {30'd0, req0_ack, req0_err}, 32'd0);
      phy_dir = 1'b0;
      tick();
      tick();
      chk("ab_reissue", {23'd0, bus_own, phy_d_out}, 32'h195);
    end
    phy_nxt = 1'b1;
    tick();
    chk("ab_data", {24'd0, phy_d_out}, 32'h3C);
    tick();
    chk("ab_stp", {31'd0, phy_stp}, 32'd1);
    phy_nxt = 1'b0;
    tick();
    chk("ab_ack", {30'd0, req0_ack, req0_err}, 32'b10);

    // Four aborts exhaust the retries: single err, never an ack.
    wait_own("ex_own");
    for (int a = 0; a < 4; a++) begin
      phy_dir = 1'b1;
      tick();
      chk("ex_release", {30'd0, bus_own, req0_ack}, 32'd0);
      phy_dir = 1'b0;
      tick();
      tick();
      if (a < 3) begin
        chk("ex_retry", {29'd0, bus_own, req0_ack, req0_err}, 32'b100);
      end else begin
        chk("ex_err", {29'd0, bus_own, req0_ack, req0_err}, 32'b001);
      end
    end
    req0_valid = 1'b0;
    tick();
    chk("ex_err_once", {31'd0, req0_err}, 32'd0);

    // NXT never comes: err on req1 after 255 cycles in CMD, no STP.
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 6'h01; req1_wdata = 8'h00;
    wait_own("to_own");
    stp_seen = 0;
    for (int i = 0; i < 254; i++) begin
      tick();
      if (phy_stp) stp_seen++;
    end
    chk("to_pre", {30'd0, bus_own, req1_err}, 32'b10);
    tick();
    if (phy_stp) stp_seen++;
    chk("to_err", {28'd0, bus_own, req1_err, req0_err, req1_ack}, 32'b0100);
    chk("to_no_stp", stp_seen, 32'd0);
    req1_valid = 1'b0;
    tick();

    // bus_busy blocks the grant; then reset hits mid-WDATA.
    bus_busy = 1'b1;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 6'h02; req0_wdata = 8'h77;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("busy_hold", {31'd0, bus_own}, 32'd0);
    end
    bus_busy = 1'b0;
    tick();
    chk("busy_grant", {23'd0, bus_own, phy_d_out}, 32'h182);
    phy_nxt = 1'b1;
    tick();
    chk("mid_wdata", {23'd0, bus_own, phy_d_out}, 32'h177);
    reset = 1'b1;
    #1;
    chk("rst_mid_bus", {22'd0, bus_own, phy_stp, phy_d_out}, 32'd0);
    chk("rst_mid_misc", {20'd0, req0_ack, req1_ack, req0_err, req1_err, rdata}, 32'd0);
    req0_valid = 1'b0; phy_nxt = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_idle", {31'd0, bus_own}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/usb2_ulpi_regarb.md
Name: usb2_ulpi_regarb

Overview:
- Round-robin arbiter and sequencer for ULPI PHY register accesses, serving two independent requesters: link-control FSM and debug/config port.
- Owns the ULPI link-side pins only while a register transaction runs. Yields whenever the packet layer is busy or the PHY takes the bus.
- Handles PHY-initiated aborts (DIR rising mid-command) with bounded retry and a timeout.
- Sits beside the ULPI packet path; its phy_* outputs are muxed in by bus_own.

Parameters:
- TIMEOUT, 255, max cycles waiting for NXT in any wait state before error (8-bit counter).
- MAX_RETRY, 3, abort-and-retry attempts before error (2-bit counter).

Ports:
- phy_clk  in  1  60 MHz ULPI clock.
- reset  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  request pending; hold until ack or err.
- req0_write / req1_write  in  1  1 = register write, 0 = register read.
- req0_addr / req1_addr  in  6  immediate register address.
- req0_wdata / req1_wdata  in  8  write data.
- req0_ack / req1_ack  out  1  one-cycle completion pulse.
- req0_err / req1_err  out  1  one-cycle failure pulse (timeout or retries exhausted).
- rdata  out  8  read result; valid on ack of a read; held until next read completes.
- bus_busy  in  1  packet layer holds the bus; no new grant while high.
- bus_own  out  1  arbiter drives phy_d_out/phy_stp.
- phy_dir  in  1  ULPI DIR.
- phy_nxt  in  1  ULPI NXT.
- phy_d_in  in  8  ULPI data from PHY.
- phy_d_out  out  8  ULPI data to PHY.
- phy_stp  out  1  ULPI STP.

Behaviour:
- Reset: state IDLE; phy_d_out=0; phy_stp=0; bus_own=0; acks=0; errs=0; rdata=0; rr pointer=0; retry=0; timer=0. Reset mid-transaction drops the bus immediately.
- dir_1 is the registered phy_dir. The bus is free when phy_dir=0, dir_1=0, and bus_busy=0.
- IDLE:
  - If the bus is free and any valid is high, grant one requester.
  - Both valid: grant the requester at the rr pointer.
  - Latch write, addr, and wdata at grant; set bus_own=1; go to CMD. Retry and timer cleared.
  - The pointer moves to the other requester only on ack/err of the granted one.
- CMD: drive phy_d_out={2'b10,addr} (write) or {2'b11,addr} (read).
  - On phy_nxt=1: write -> WDATA, driving wdata next cycle; read -> RD_TURN, driving 0.
- WDATA: drive wdata until phy_nxt=1, then go to STP.
- STP: phy_stp=1 and phy_d_out=0 for exactly one cycle; pulse ack; bus_own=0; go to IDLE.
- RD_TURN: phy_d_out=0; wait for phy_dir=1 (turnaround cycle), then go to RD_DATA.
  - If phy_nxt=1 in the same cycle DIR rises, a receive packet has pre-empted the read: treat as abort.
- RD_DATA: capture rdata<=phy_d_in (first cycle after turnaround); pulse ack; go to WAIT_IDLE.
- WAIT_IDLE: bus_own=0 once DIR is high; return to IDLE when phy_dir=0.
- Abort: phy_dir rising in CMD, WDATA, STP-pending, or the RD_TURN receive case.
  - Actions: bus_own=0, phy_d_out=0, no STP, go to ABORT.
  - ABORT waits for phy_dir=0 and dir_1=0.
  - retry<MAX_RETRY: retry+1, re-enter CMD with the same latched request (no re-arbitration).
  - Otherwise: pulse err, go to IDLE.
- Timeout: timer increments each cycle in CMD/WDATA/RD_TURN while no progress. On reaching TIMEOUT: drop bus, pulse err, go to IDLE (no STP).
- ack and err are mutually exclusive and only go to the granted requester. Requesters deasserting valid early is illegal (not checked).
- phy_stp is asserted only in STP.

Test Plan:
- Write, addr 6'h04, data 8'h45; PHY NXT after 2 cycles, then NXT on data. Required: phy_d_out=8'h84 then 8'h45; STP high exactly one cycle with d_out=0; req0_ack one cycle; bus_own falls.
- Read, addr 6'h0A; PHY NXT, DIR up, next cycle d_in=8'h5A. Required: rdata=8'h5A with ack; no STP; bus_own low during DIR.
- Both requesters valid continuously, 4 writes each. Required: grants alternate 0,1,0,1…, starting with req0 after reset.
- DIR rises during CMD twice, then the transaction completes. Required: two silent retries, single ack, original addr/data reissued. With MAX_RETRY+1 aborts: single err, no ack.
- NXT never asserted. Required: err after 255 cycles in CMD; bus_own=0; STP never asserted.
- bus_busy high with req pending. Required: no grant until bus_busy low. Reset asserted mid-WDATA: all outputs return to reset values immediately.
